axi_bridge_ip_rx_des_beat_asm: RTL and testbench

RX-side counterpart of the TX segment serializer. It accepts IF_W-wide link segments (data/keep/user/sop/eop) from the chiplet-link RX interface. It packs them LSB-first into DATA_W-wide AXI-Stream beats and presents each beat through a single output register with valid/ready. It sits between the link RX datapath and the AXI bridge RX egress, and also provides stats pulses and protocol-error pulses.

---
 rtl/axi_bridge_ip_rx_des_beat_asm.sv | 212 +++++++++++++++++++++
 tb/tb_axi_bridge_ip_rx_des_beat_asm.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_bridge_ip_rx_des_beat_asm.sv
// RX beat assembler: packs IF_W-wide link segments LSB-first into DATA_W-wide
// AXI-Stream beats held in a single output register stage. Also tracks frame
// boundaries and emits stats and protocol-error pulses.
module axi_bridge_ip_rx_des_beat_asm #(
  parameter int DATA_W  = 256,
  parameter int IF_W    = 64,
  parameter int TUSER_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                flush_i,
  input  logic                cl_rx_valid_i,
  input  logic [IF_W-1:0]     cl_rx_data_i,
  input  logic [IF_W/8-1:0]   cl_rx_keep_i,
  input  logic [TUSER_W-1:0]  cl_rx_user_i,
  input  logic                cl_rx_sop_i,
  input  logic                cl_rx_eop_i,
  output logic                cl_rx_ready_o,
  output logic                m_axis_tvalid_o,
  input  logic                m_axis_tready_i,
  output logic [DATA_W-1:0]   m_axis_tdata_o,
  output logic [DATA_W/8-1:0] m_axis_tkeep_o,
  output logic [TUSER_W-1:0]  m_axis_tuser_o,
  output logic                m_axis_tlast_o,
  output logic                beat_done_pulse_o,
  output logic                frame_done_pulse_o,
  output logic                stall_cycle_en_o,
  output logic                in_packet_o,
  output logic                err_orphan_pulse_o,
  output logic                err_sop_pulse_o,
  output logic                err_keep_pulse_o
);

  localparam int BYTES_PER_SEG = IF_W / 8;
  localparam int SEGS_PER_BEAT = DATA_W / IF_W;
  localparam int SEG_CNT_W     = $clog2(SEGS_PER_BEAT + 1);
  localparam int KEEP_W        = DATA_W / 8;

  // Keep must be non-zero, contiguous from byte 0, and full unless it ends the frame.
  // keep & (keep + 1) is zero exactly when keep is a run of ones starting at bit 0.
  function automatic logic keep_is_bad(input logic [BYTES_PER_SEG-1:0] keep,
                                       input logic eop);
    logic [BYTES_PER_SEG-1:0] plus_one;
    plus_one    = keep + BYTES_PER_SEG'(1);
    keep_is_bad = (keep == '0) || ((keep & plus_one) != '0) || (!eop && (keep != '1));
  endfunction

  // Assembly state
  logic [SEG_CNT_W-1:0] slot_idx_q, slot_idx_d;
  logic [DATA_W-1:0]    asm_data_q, asm_data_d;
  logic [KEEP_W-1:0]    asm_keep_q, asm_keep_d;
  logic                 in_packet_q, in_packet_d;
  logic [TUSER_W-1:0]   frame_user_q, frame_user_d;

  // Output register stage
  logic                 tvalid_q, tvalid_d;
  logic [DATA_W-1:0]    tdata_q, tdata_d;
  logic [KEEP_W-1:0]    tkeep_q, tkeep_d;
  logic [TUSER_W-1:0]   tuser_q, tuser_d;
  logic                 tlast_q, tlast_d;

  // Combinational helpers
  logic                 seg_ready_s;
  logic                 seg_fire_s;
  logic                 out_fire_s;
  logic                 orphan_s;
  logic                 sop_eff_s;
  logic                 sop_err_s;
  logic                 pack_s;
  logic                 complete_s;
  logic [DATA_W-1:0]    asm_data_s;
  logic [KEEP_W-1:0]    asm_keep_s;

  // Handshake qualifiers and segment classification.
  // Reset holds ready low so nothing is accepted and no pulse fires while in reset.
  always_comb begin
    seg_ready_s = !rst_i && enable_i && !flush_i && (!tvalid_q || m_axis_tready_i);
    seg_fire_s  = cl_rx_valid_i && seg_ready_s;
    out_fire_s  = tvalid_q && m_axis_tready_i;
    orphan_s    = !in_packet_q && !cl_rx_sop_i;
    sop_eff_s   = cl_rx_sop_i && !in_packet_q;
    sop_err_s   = cl_rx_sop_i && in_packet_q;
    pack_s      = seg_fire_s && !orphan_s;
    complete_s  = pack_s &&
                  ((slot_idx_q == SEG_CNT_W'(SEGS_PER_BEAT - 1)) || cl_rx_eop_i);
  end

  // Assembly buffer with the incoming segment merged into the current slot.
  always_comb begin
    asm_data_s = asm_data_q;
    asm_keep_s = asm_keep_q;
    for (int s = 0; s < SEGS_PER_BEAT; s++) begin
      if (slot_idx_q == SEG_CNT_W'(s)) begin
        asm_data_s[s*IF_W +: IF_W]                   = cl_rx_data_i;
        asm_keep_s[s*BYTES_PER_SEG +: BYTES_PER_SEG] = cl_rx_keep_i;
      end else begin
        asm_data_s[s*IF_W +: IF_W]                   = asm_data_q[s*IF_W +: IF_W];
        asm_keep_s[s*BYTES_PER_SEG +: BYTES_PER_SEG] = asm_keep_q[s*BYTES_PER_SEG +: BYTES_PER_SEG];
      end
    end
  end

  // Next-state logic for assembly, frame tracking and the output register.
  always_comb begin
    slot_idx_d   = slot_idx_q;
    asm_data_d   = asm_data_q;
    asm_keep_d   = asm_keep_q;
    in_packet_d  = in_packet_q;
    frame_user_d = frame_user_q;
    tvalid_d     = tvalid_q;
    tdata_d      = tdata_q;
    tkeep_d      = tkeep_q;
    tuser_d      = tuser_q;
    tlast_d      = tlast_q;

    if (flush_i) begin
      // Drop partial assembly and any beat waiting on the output.
      slot_idx_d  = '0;
      asm_data_d  = '0;
      asm_keep_d  = '0;
      in_packet_d = 1'b0;
      tvalid_d    = 1'b0;
    end else begin
      if (out_fire_s) begin
        tvalid_d = 1'b0;
      end else begin
        tvalid_d = tvalid_q;
      end

      if (pack_s) begin
        if (complete_s) begin
          // A completing segment overrides the drain above: back-to-back beats.
          tvalid_d   = 1'b1;
          tdata_d    = asm_data_s;
          tkeep_d    = asm_keep_s;
          tlast_d    = cl_rx_eop_i;
          tuser_d    = sop_eff_s ? cl_rx_user_i : frame_user_q;
          slot_idx_d = '0;
          asm_data_d = '0;
          asm_keep_d = '0;
        end else begin
          asm_data_d = asm_data_s;
          asm_keep_d = asm_keep_s;
          slot_idx_d = slot_idx_q + SEG_CNT_W'(1);
        end

        if (sop_eff_s) begin
          frame_user_d = cl_rx_user_i;
        end else begin
          frame_user_d = frame_user_q;
        end

        // EOP wins so a single-segment frame leaves in_packet low.
        if (cl_rx_eop_i) begin
          in_packet_d = 1'b0;
        end else if (sop_eff_s) begin
          in_packet_d = 1'b1;
        end else begin
          in_packet_d = in_packet_q;
        end
      end else begin
        slot_idx_d = slot_idx_q;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_idx_q   <= '0;
      asm_data_q   <= '0;
      asm_keep_q   <= '0;
      in_packet_q  <= 1'b0;
      frame_user_q <= '0;
      tvalid_q     <= 1'b0;
      tdata_q      <= '0;
      tkeep_q      <= '0;
      tuser_q      <= '0;
      tlast_q      <= 1'b0;
    end else begin
      slot_idx_q   <= slot_idx_d;
      asm_data_q   <= asm_data_d;
      asm_keep_q   <= asm_keep_d;
      in_packet_q  <= in_packet_d;
      frame_user_q <= frame_user_d;
      tvalid_q     <= tvalid_d;
      tdata_q      <= tdata_d;
      tkeep_q      <= tkeep_d;
      tuser_q      <= tuser_d;
      tlast_q      <= tlast_d;
    end
  end

  // Output ports; pulses are combinational and suppressed while in reset.
  always_comb begin
    cl_rx_ready_o      = seg_ready_s;
    m_axis_tvalid_o    = tvalid_q;
    m_axis_tdata_o     = tdata_q;
    m_axis_tkeep_o     = tkeep_q;
    m_axis_tuser_o     = tuser_q;
    m_axis_tlast_o     = tlast_q;
    in_packet_o        = in_packet_q;
    beat_done_pulse_o  = !rst_i && out_fire_s;
    frame_done_pulse_o = !rst_i && out_fire_s && tlast_q;
    stall_cycle_en_o   = !rst_i && tvalid_q && !m_axis_tready_i;
    err_orphan_pulse_o = seg_fire_s && orphan_s;
    err_sop_pulse_o    = seg_fire_s && sop_err_s;
    err_keep_pulse_o   = pack_s && keep_is_bad(cl_rx_keep_i, cl_rx_eop_i);
  end

endmodule

// File: tb/tb_axi_bridge_ip_rx_des_beat_asm.sv
// Self-checking bench for the RX beat assembler: directed frames followed by
// randomized traffic, all checked against a queue-based frame model.
module tb_axi_bridge_ip_rx_des_beat_asm;

  localparam int DW   = 256;
  localparam int IW   = 64;
  localparam int UW   = 16;
  localparam int SEGS = DW / IW;

  logic           clk = 1'b0;
  logic           rst, en, fl, v, sop, eop, tready;
  logic [IW-1:0]  data;
  logic [7:0]     keep;
  logic [UW-1:0]  user;
  logic           ready, tvalid, tlast, bd, fd, stall, inpkt_o, e_orph, e_sop, e_keep;
  logic [DW-1:0]  tdata;
  logic [31:0]    tkeep;
  logic [UW-1:0]  tuser;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic [31:0]   k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  beat_t         bq[$];
  logic [IW-1:0] cur_d[$];
  logic [7:0]    cur_k[$];
  logic          m_inpkt;
  logic [UW-1:0] m_fuser;

  always #5 clk = ~clk;

  axi_bridge_ip_rx_des_beat_asm #(.DATA_W(DW), .IF_W(IW), .TUSER_W(UW)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .flush_i(fl),
    .cl_rx_valid_i(v), .cl_rx_data_i(data), .cl_rx_keep_i(keep), .cl_rx_user_i(user),
    .cl_rx_sop_i(sop), .cl_rx_eop_i(eop), .cl_rx_ready_o(ready),
    .m_axis_tvalid_o(tvalid), .m_axis_tready_i(tready), .m_axis_tdata_o(tdata),
    .m_axis_tkeep_o(tkeep), .m_axis_tuser_o(tuser), .m_axis_tlast_o(tlast),
    .beat_done_pulse_o(bd), .frame_done_pulse_o(fd), .stall_cycle_en_o(stall),
    .in_packet_o(inpkt_o), .err_orphan_pulse_o(e_orph), .err_sop_pulse_o(e_sop),
    .err_keep_pulse_o(e_keep)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_keep_bad(input logic [7:0] k, input logic e);
    int n;
    int m;
    n = $countones(k);
    m = (1 << n) - 1;
    return (n == 0) || (k != m[7:0]) || (!e && (k != 8'hFF));
  endfunction

  // One clock: check everything at the falling edge, advance the model, return after posedge.
  task automatic tick();
    beat_t b;
    logic vld, er, sf, orph, serr, kerr, sop_eff;
    @(negedge clk);
    vld = (bq.size() != 0);
    er  = !rst && en && !fl && (!vld || tready);
    chk("ready", ready, er);
    chk("tvalid", tvalid, vld);
    chk("stall", stall, !rst && vld && !tready);
    chk("beat_done", bd, !rst && vld && tready);
    chk("in_packet", inpkt_o, m_inpkt);
    if (vld) begin
      b = bq[0];
      chk("tdata", tdata, b.d);
      chk("tkeep", tkeep, b.k);
      chk("tuser", tuser, b.u);
      chk("tlast", tlast, b.l);
      chk("frame_done", fd, !rst && tready && b.l);
    end else begin
      chk("frame_done_idle", fd, 1'b0);
    end
    sf   = v && er;
    orph = sf && !m_inpkt && !sop;
    serr = sf && m_inpkt && sop;
    kerr = sf && !orph && model_keep_bad(keep, eop);
    chk("err_orphan", e_orph, orph);
    chk("err_sop", e_sop, serr);
    chk("err_keep", e_keep, kerr);

    if (rst || fl) begin
      bq.delete(); cur_d.delete(); cur_k.delete();
      m_inpkt = 1'b0;
    end else begin
      if (vld && tready) void'(bq.pop_front());
      if (sf && !orph) begin
        sop_eff = sop && !m_inpkt;
        if (sop_eff) m_fuser = user;
        cur_d.push_back(data);
        cur_k.push_back(keep);
        if (cur_d.size() == SEGS || eop) begin
          b.d = '0; b.k = '0;
          foreach (cur_d[i]) begin
            b.d[i*IW +: IW] = cur_d[i];
            b.k[i*8 +: 8]   = cur_k[i];
          end
          b.u = m_fuser; b.l = eop;
          bq.push_back(b);
          cur_d.delete(); cur_k.delete();
        end
        if (eop) m_inpkt = 1'b0;
        else if (sop_eff) m_inpkt = 1'b1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic seg(input logic s, input logic e, input logic [IW-1:0] d,
                     input logic [7:0] k, input logic [UW-1:0] u);
    v = 1'b1; sop = s; eop = e; data = d; keep = k; user = u;
    tick();
    v = 1'b0; sop = 1'b0; eop = 1'b0;
  endtask

  logic [DW-1:0] held;
  logic [7:0]    rk;
  int            rn, rm;

  initial begin
    rst = 1'b1; en = 1'b0; fl = 1'b0; v = 1'b0; sop = 1'b0; eop = 1'b0;
    tready = 1'b1; data = '0; keep = '0; user = '0;
    m_inpkt = 1'b0; m_fuser = '0;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_tdata", tdata, '0);
    chk("rst_tkeep", tkeep, '0);
    chk("rst_tuser", tuser, '0);
    chk("rst_tlast", tlast, 1'b0);
    chk("rst_inpkt", inpkt_o, 1'b0);
    chk("rst_ready", ready, 1'b0);
    rst = 1'b0; en = 1'b1;
    tick();

    // full 4-segment frame
    seg(1'b1, 1'b0, 64'h0000_0000_0000_00D0, 8'hFF, 16'hA5A5);
    seg(1'b0, 1'b0, 64'h1111_1111_1111_11D1, 8'hFF, 16'h0000);
    seg(1'b0, 1'b0, 64'h2222_2222_2222_22D2, 8'hFF, 16'h0000);
    seg(1'b0, 1'b1, 64'h3333_3333_3333_33D3, 8'hFF, 16'h0000);
    chk("t1_tdata", tdata, {64'h3333_3333_3333_33D3, 64'h2222_2222_2222_22D2,
                            64'h1111_1111_1111_11D1, 64'h0000_0000_0000_00D0});
    chk("t1_tkeep", tkeep, 32'hFFFF_FFFF);
    chk("t1_tlast", tlast, 1'b1);
    chk("t1_tuser", tuser, 16'hA5A5);
    tick();

    // 6-segment frame with partial last segment
    for (int i = 0; i < 6; i++) begin
      seg(i == 0, i == 5, {$urandom, $urandom}, (i == 5) ? 8'h0F : 8'hFF, 16'h1234);
      if (i == 3) begin
        chk("t2_b1_tkeep", tkeep, 32'hFFFF_FFFF);
        chk("t2_b1_tlast", tlast, 1'b0);
      end
    end
    chk("t2_b2_tkeep", tkeep, 32'h0000_0FFF);
    chk("t2_b2_tlast", tlast, 1'b1);
    chk("t2_b2_upper", tdata[255:128], '0);
    tick();

    // single-segment frame
    seg(1'b1, 1'b1, 64'h0000_0000_00AB_CDEF, 8'h07, 16'h0777);
    chk("t3_tkeep", tkeep, 32'h0000_0007);
    chk("t3_tlast", tlast, 1'b1);
    chk("t3_inpkt", inpkt_o, 1'b0);
    tick();

    // backpressure for three cycles
    for (int i = 0; i < 4; i++) begin
      if (i == 3) tready = 1'b0;
      seg(i == 0, i == 3, {$urandom, $urandom}, 8'hFF, 16'h4444);
    end
    held = tdata;
    repeat (3) tick();
    chk("t4_stable", tdata, held);
    tready = 1'b1;
    tick();

    // errors: orphan, SOP mid-frame, partial keep without eop
    seg(1'b0, 1'b0, 64'hDEAD, 8'hFF, 16'h0000);
    chk("t5_orphan_nobeat", tvalid, 1'b0);
    seg(1'b1, 1'b0, 64'h1, 8'hFF, 16'hAAAA);
    seg(1'b1, 1'b0, 64'h2, 8'hFF, 16'hBBBB);
    seg(1'b0, 1'b0, 64'h3, 8'h0F, 16'h0000);
    seg(1'b0, 1'b1, 64'h4, 8'hFF, 16'h0000);
    chk("t5_user_kept", tuser, 16'hAAAA);
    tick();

    // flush, then reset, each after two of four segments
    for (int pass = 0; pass < 2; pass++) begin
      seg(1'b1, 1'b0, 64'h5555, 8'hFF, 16'h5555);
      seg(1'b0, 1'b0, 64'h6666, 8'hFF, 16'h5555);
      if (pass == 0) fl = 1'b1; else rst = 1'b1;
      tick();
      fl = 1'b0; rst = 1'b0;
      chk("t6_tvalid", tvalid, 1'b0);
      chk("t6_inpkt", inpkt_o, 1'b0);
      for (int i = 0; i < 4; i++)
        seg(i == 0, i == 3, 64'h7000 + 64'(i), 8'hFF, 16'h7777);
      chk("t6_tdata", tdata, {64'h7003, 64'h7002, 64'h7001, 64'h7000});
      tick();
    end

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      v      = ($urandom_range(0, 3) != 0);
      sop    = m_inpkt ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 7) != 0);
      eop    = ($urandom_range(0, 4) == 0);
      data   = {$urandom, $urandom};
      user   = UW'($urandom);
      tready = ($urandom_range(0, 3) != 0);
      en     = ($urandom_range(0, 15) != 0);
      fl     = ($urandom_range(0, 63) == 0);
      rst    = ($urandom_range(0, 255) == 0);
      rn     = $urandom_range(1, 8);
      rm     = (1 << rn) - 1;
      rk     = ($urandom_range(0, 9) == 0) ? 8'($urandom) : (eop ? rm[7:0] : 8'hFF);
      keep   = rk;
      tick();
    end
    v = 1'b0; rst = 1'b0; fl = 1'b0; en = 1'b1; tready = 1'b1;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
